// File: rtl/axis_narrow_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_narrow_link_arbiter
// Brief    : Packet-locked round-robin arbiter sharing one AXI Stream sink
//            between N_REQ sources. Optional macro: AXIS_ARB_TDEST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axis_narrow_link_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DAT_BITS = 384,
  parameter int IDX_BITS = $clog2(N_REQ)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [N_REQ-1:0]          s_axis_tvalid,
  output logic [N_REQ-1:0]          s_axis_tready,
  input  logic [N_REQ*DAT_BITS-1:0] s_axis_tdata,
  input  logic [N_REQ-1:0]          s_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DAT_BITS-1:0]       m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic [IDX_BITS-1:0]       grant_idx,
  output logic                      busy
`ifdef AXIS_ARB_TDEST_EN
  ,
  output logic [IDX_BITS-1:0]       m_axis_tdest,
  output logic [N_REQ*16-1:0]       pkt_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam logic [IDX_BITS-1:0] c_RR_RESET = IDX_BITS'(N_REQ - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_BITS-1:0]   r_grant_idx;
  logic [IDX_BITS-1:0]   r_rr_ptr;
  logic [IDX_BITS-1:0]   w_grant_nxt;
  logic [IDX_BITS-1:0]   w_rr_nxt;
  logic [IDX_BITS-1:0]   w_pick;
  logic                  w_any_req;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [DAT_BITS-1:0]   w_sel_data;
  logic                  w_pkt_done;
  int                    w_dist;
  int                    w_best;

  // Pick the requester closest above rr_ptr (distance 0 is rr_ptr+1, wrapping).
  always_comb begin
    w_pick = '0;
    w_best = N_REQ;
    w_dist = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_dist = i - int'(r_rr_ptr) - 1;
      if (w_dist < 0) begin
        w_dist = w_dist + N_REQ;
      end
      if (s_axis_tvalid[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_pick = IDX_BITS'(i);
      end
    end
  end

  assign w_any_req = |s_axis_tvalid;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant_idx == IDX_BITS'(i)) begin
        w_sel_valid = s_axis_tvalid[i];
        w_sel_last  = s_axis_tlast[i];
        w_sel_data  = s_axis_tdata[i*DAT_BITS +: DAT_BITS];
      end
    end
  end

  assign w_pkt_done = (r_state == ST_LOCK) && w_sel_valid && m_axis_tready && w_sel_last;

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant_idx;
    w_rr_nxt      = r_rr_ptr;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_LOCK;
          w_grant_nxt = w_pick;
        end
      end
      ST_LOCK: begin
        m_axis_tvalid = w_sel_valid;
        for (int i = 0; i < N_REQ; i++) begin
          if (r_grant_idx == IDX_BITS'(i)) begin
            s_axis_tready[i] = m_axis_tready;
          end
        end
        if (w_pkt_done) begin
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = r_grant_idx;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state     <= ST_IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= c_RR_RESET;
    end else begin
      r_state     <= w_state_nxt;
      r_grant_idx <= w_grant_nxt;
      r_rr_ptr    <= w_rr_nxt;
    end
  end

  assign m_axis_tdata = w_sel_data;
  assign m_axis_tlast = w_sel_last;
  assign grant_idx    = r_grant_idx;
  assign busy         = (r_state == ST_LOCK);

`ifdef AXIS_ARB_TDEST_EN
  assign m_axis_tdest = m_axis_tvalid ? r_grant_idx : '0;

  for (genvar g = 0; g < N_REQ; g++) begin : g_pkt_cnt
    logic [15:0] r_cnt;
    always_ff @(posedge aclk) begin
      if (!aresetn) begin
        r_cnt <= '0;
      end else if (w_pkt_done && (r_grant_idx == IDX_BITS'(g))) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
    assign pkt_cnt[g*16 +: 16] = r_cnt;
  end
`endif

endmodule
`default_nettype wire
